// File: rtl/platform_spawner_if.sv
// platform_spawner_if: bundles the random feed, scroll handshake and slot read port of
// platform_spawner.
//   master : producer side (random source, camera, renderer/collision readers)
//   slave  : platform_spawner itself
// Signals:
//   rnd          15-bit random word, new value every cycle
//   scroll_valid scroll request; scroll_dy scroll distance 0..31 px
//   scroll_ready spawner idle and able to take a scroll
//   rd_idx       slot to read; rd_x / rd_y / rd_type / rd_alive slot contents
//   busy         initialisation or scroll pass in progress
interface platform_spawner_if #(
   parameter int unsigned SLOTS = 8
);
   logic [14:0]              rnd;
   logic                     scroll_valid;
   logic [4:0]               scroll_dy;
   logic                     scroll_ready;
   logic [$clog2(SLOTS)-1:0] rd_idx;
   logic [9:0]               rd_x;
   logic signed [10:0]       rd_y;
   logic [1:0]               rd_type;
   logic                     rd_alive;
   logic                     busy;

   modport master (
      output rnd, scroll_valid, scroll_dy, rd_idx,
      input  scroll_ready, rd_x, rd_y, rd_type, rd_alive, busy
   );

   modport slave (
      input  rnd, scroll_valid, scroll_dy, rd_idx,
      output scroll_ready, rd_x, rd_y, rd_type, rd_alive, busy
   );
endinterface

// File: rtl/platform_spawner.sv
// platform_spawner: keeps a fixed pool of platform slots (x, y, type, alive). After reset it
// fills every slot, then on each scroll request shifts all platforms down by dy and respawns
// any platform that falls off the bottom above the current topmost one, using the LFSR word
// for x, vertical gap and type.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset (aborts any pass and restarts initialisation)
//   bus  platform_spawner_if.slave: rnd, scroll handshake, indexed slot read port, busy
// Optional feature: define PLATFORM_MOVING_EN to spawn moving (type 2) platforms that bounce
// one pixel left/right per scroll pass between x=0 and x=SCREEN_W-PLAT_W.
module platform_spawner #(
   parameter int unsigned SLOTS    = 8,
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480,
   parameter int unsigned PLAT_W   = 64,
   parameter int unsigned MIN_GAP  = 24
) (
   input logic               clk,
   input logic               rst,
   platform_spawner_if.slave bus
);

   localparam int unsigned IW = $clog2(SLOTS);
   localparam int unsigned XRANGE = SCREEN_W - PLAT_W;
   localparam logic [9:0] XRange = 10'(XRANGE);
   localparam logic [9:0] XCenter = 10'(XRANGE / 2);
   localparam logic signed [10:0] YBottom = 11'(SCREEN_H);
   localparam logic signed [10:0] YFirst = 11'(SCREEN_H - 16);
   localparam logic [IW:0] CntLastInit = (IW + 1)'(SLOTS - 1);
   localparam logic [IW:0] CntLastScroll = (IW + 1)'(SLOTS);

   typedef enum logic [1:0] {StInit, StIdle, StScroll, StDone} state_e;

   state_e state_q, state_d;
   logic [IW:0] cnt_q, cnt_d;
   logic [4:0] dy_q, dy_d;
   logic signed [10:0] top_q, top_d;

   logic [9:0]         x_q     [SLOTS];
   logic signed [10:0] y_q     [SLOTS];
   logic [1:0]         type_q  [SLOTS];
   logic               alive_q [SLOTS];

   // Single slot write port; INIT and SCROLL each touch at most one slot per cycle.
   logic               wr_en;
   logic [IW-1:0]      wr_idx;
   logic [9:0]         wr_x;
   logic signed [10:0] wr_y;
   logic [1:0]         wr_type;

   logic [9:0]         spawn_x;
   logic signed [10:0] spawn_gap;
   logic signed [10:0] spawn_y;
   logic [1:0]         spawn_type;

   logic [IW:0]        cnt_m1;
   logic [IW-1:0]      k;
   logic signed [10:0] y_new;
   logic [9:0]         mv_x;

`ifdef PLATFORM_MOVING_EN
   logic dir_q [SLOTS];
   logic wr_dir;
   logic mv_dir;
`endif

   // Random field extraction; only consumed on cycles that spawn a platform.
   always_comb begin
      spawn_x = (bus.rnd[9:0] < XRange) ? bus.rnd[9:0] : bus.rnd[9:0] - XRange;
      spawn_gap = $signed(11'(MIN_GAP) + {6'b0, bus.rnd[14:10]});
      spawn_y = top_q - spawn_gap;
      spawn_type = 2'd0;
      if (bus.rnd[12:11] == 2'b11) begin
         spawn_type = 2'd1;
      end
`ifdef PLATFORM_MOVING_EN
      if (bus.rnd[12:11] == 2'b10) begin
         spawn_type = 2'd2;
      end
`endif
   end

   // Slot handled in SCROLL cycle cnt_q (cycle 0 only adjusts top_y).
   always_comb begin
      cnt_m1 = cnt_q - 1'b1;
      k = cnt_m1[IW-1:0];
      y_new = y_q[k] + $signed({6'b0, dy_q});
      mv_x = x_q[k];
`ifdef PLATFORM_MOVING_EN
      mv_dir = dir_q[k];
      if (type_q[k] == 2'd2) begin
         mv_x = dir_q[k] ? x_q[k] - 10'd1 : x_q[k] + 10'd1;
         // Bounce at either edge so x stays within 0..XRANGE.
         if (mv_x == 10'd0 || mv_x == XRange) begin
            mv_dir = ~dir_q[k];
         end
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      dy_d = dy_q;
      top_d = top_q;
      wr_en = 1'b0;
      wr_idx = cnt_q[IW-1:0];
      wr_x = spawn_x;
      wr_y = spawn_y;
      wr_type = spawn_type;
`ifdef PLATFORM_MOVING_EN
      wr_dir = 1'b0;
`endif
      bus.scroll_ready = 1'b0;
      bus.busy = 1'b1;

      unique case (state_q)
         StInit: begin
            wr_en = 1'b1;
            // Slot 0 is a fixed landing platform near the bottom of the screen.
            if (cnt_q == '0) begin
               wr_x = XCenter;
               wr_y = YFirst;
               wr_type = 2'd0;
            end
            top_d = wr_y;
            if (cnt_q == CntLastInit) begin
               cnt_d = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StIdle: begin
            bus.scroll_ready = 1'b1;
            bus.busy = 1'b0;
            if (bus.scroll_valid) begin
               dy_d = bus.scroll_dy;
               cnt_d = '0;
               state_d = StScroll;
            end
         end
         StScroll: begin
            if (cnt_q == '0) begin
               top_d = top_q + $signed({6'b0, dy_q});
            end else begin
               wr_en = 1'b1;
               wr_idx = k;
               if (y_new >= YBottom) begin
                  // Respawn above the topmost platform; later slots chain off the new top.
                  top_d = spawn_y;
               end else begin
                  wr_x = mv_x;
                  wr_y = y_new;
                  wr_type = type_q[k];
`ifdef PLATFORM_MOVING_EN
                  wr_dir = mv_dir;
`endif
               end
            end
            if (cnt_q == CntLastScroll) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StInit;
         cnt_q <= '0;
         dy_q <= '0;
         top_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         dy_q <= dy_d;
         top_q <= top_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(SLOTS); i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            type_q[i] <= '0;
            alive_q[i] <= 1'b0;
`ifdef PLATFORM_MOVING_EN
            dir_q[i] <= 1'b0;
`endif
         end
      end else if (wr_en) begin
         x_q[wr_idx] <= wr_x;
         y_q[wr_idx] <= wr_y;
         type_q[wr_idx] <= wr_type;
         alive_q[wr_idx] <= 1'b1;
`ifdef PLATFORM_MOVING_EN
         dir_q[wr_idx] <= wr_dir;
`endif
      end
   end

   assign bus.rd_x = x_q[bus.rd_idx];
   assign bus.rd_y = y_q[bus.rd_idx];
   assign bus.rd_type = type_q[bus.rd_idx];
   assign bus.rd_alive = alive_q[bus.rd_idx];

endmodule

// File: tb/tb_platform_spawner.sv
// tb_platform_spawner: directed self-checking bench for platform_spawner (SLOTS=8).
// Covers reset state, initial fill, scroll with retirement, random field extraction,
// ready latency, requests while busy, held requests, and reset mid-pass.
// Define PLATFORM_MOVING_EN to also exercise moving-platform bounce.
module tb_platform_spawner;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   platform_spawner_if #(.SLOTS(8)) bus ();

   platform_spawner #(.SLOTS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int ex[8];
   int ey[8];
   int et[8];

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_slot(input int i, input int x, input int y, input int t, input int a);
      logic [2:0] idx;
      idx = 3'(i);
      bus.rd_idx = idx;
      #1;
      check($sformatf("s%0d_x", i), int'(bus.rd_x), x);
      check($sformatf("s%0d_y", i), int'(bus.rd_y), y);
      check($sformatf("s%0d_type", i), int'(bus.rd_type), t);
      check($sformatf("s%0d_alive", i), int'(bus.rd_alive), a);
   endtask

   task automatic check_all(input int a);
      for (int i = 0; i < 8; i++) begin
         check_slot(i, ex[i], ey[i], et[i], a);
      end
   endtask

   // Waits for scroll_ready with a cycle bound; returns edges counted since the call.
   task automatic wait_ready(output int n);
      n = 0;
      while (!bus.scroll_ready && n < 40) begin
         tick(1);
         n++;
      end
   endtask

   // Issues one scroll from IDLE; optionally pokes an extra request while the pass runs.
   task automatic do_scroll(input int dy, input bit poke, input string tag);
      int n;
      bus.scroll_valid = 1'b1;
      bus.scroll_dy = 5'(dy);
      tick(1);
      bus.scroll_valid = 1'b0;
      check({tag, "_accept_ready"}, int'(bus.scroll_ready), 0);
      check({tag, "_accept_busy"}, int'(bus.busy), 1);
      n = 0;
      while (!bus.scroll_ready && n < 40) begin
         if (poke && n == 3) begin
            bus.scroll_valid = 1'b1;
            bus.scroll_dy = 5'd31;
         end else begin
            bus.scroll_valid = 1'b0;
         end
         tick(1);
         n++;
      end
      bus.scroll_valid = 1'b0;
      check({tag, "_latency"}, n, 10);
   endtask

   task automatic init_expect_rnd0();
      ex[0] = 288; ey[0] = 464; et[0] = 0;
      for (int i = 1; i < 8; i++) begin
         ex[i] = 0; ey[i] = 464 - 24 * i; et[i] = 0;
      end
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bus.rnd = '0;
      bus.scroll_valid = 1'b0;
      bus.scroll_dy = '0;
      bus.rd_idx = '0;

      // Reset state.
      tick(1);
      check("rst_busy", int'(bus.busy), 1);
      check("rst_ready", int'(bus.scroll_ready), 0);
      for (int i = 0; i < 8; i++) begin
         ex[i] = 0; ey[i] = 0; et[i] = 0;
      end
      check_all(0);
      rst = 1'b0;

      // Initial fill takes exactly 8 cycles.
      tick(7);
      check("init_ready_early", int'(bus.scroll_ready), 0);
      tick(1);
      check("init_ready", int'(bus.scroll_ready), 1);
      check("init_busy", int'(bus.busy), 0);
      init_expect_rnd0();
      check_all(1);

      // dy=20: slot 0 retires to y=316-24; a request during the pass must be dropped.
      do_scroll(20, 1'b1, "sc1");
      ex[0] = 0; ey[0] = 292;
      for (int i = 1; i < 8; i++) ey[i] = ey[i] + 20;
      check_all(1);

      // rnd=7FFF: slot 1 retires with x=447, gap=55 from top 312, type 1.
      bus.rnd = 15'h7FFF;
      do_scroll(20, 1'b0, "sc2");
      bus.rnd = '0;
      for (int i = 0; i < 8; i++) ey[i] = ey[i] + 20;
      ex[1] = 447; ey[1] = 257; et[1] = 1;
      check_all(1);

      // Held request with dy=0: back-to-back passes, one per IDLE cycle, nothing moves.
      bus.scroll_valid = 1'b1;
      bus.scroll_dy = 5'd0;
      tick(1);
      check("hold_accept1", int'(bus.scroll_ready), 0);
      wait_ready(n);
      check("hold_lat1", n, 10);
      tick(1);
      check("hold_accept2_ready", int'(bus.scroll_ready), 0);
      check("hold_accept2_busy", int'(bus.busy), 1);
      bus.scroll_valid = 1'b0;
      wait_ready(n);
      check("hold_lat2", n, 10);
      tick(1);
      check("hold_stays_idle", int'(bus.scroll_ready), 1);
      check_all(1);

      // Reset at SCROLL cycle 4 aborts the pass and clears every slot.
      bus.scroll_valid = 1'b1;
      bus.scroll_dy = 5'd5;
      tick(1);
      bus.scroll_valid = 1'b0;
      tick(4);
      rst = 1'b1;
      tick(1);
      check("mid_rst_busy", int'(bus.busy), 1);
      check("mid_rst_ready", int'(bus.scroll_ready), 0);
      for (int i = 0; i < 8; i++) begin
         ex[i] = 0; ey[i] = 0; et[i] = 0;
      end
      check_all(0);
      rst = 1'b0;
      tick(1);
      check_slot(0, 288, 464, 0, 1);
      check_slot(1, 0, 0, 0, 0);
      wait_ready(n);
      check("reinit_lat", n, 7);
      init_expect_rnd0();
      check_all(1);

`ifdef PLATFORM_MOVING_EN
      // rnd=0x123F: x=575, gap=28, type 2 for every random slot; dy=0 passes only move them.
      rst = 1'b1;
      bus.rnd = 15'h123F;
      tick(1);
      rst = 1'b0;
      wait_ready(n);
      check_slot(1, 575, 436, 2, 1);
      do_scroll(0, 1'b0, "mv1");
      check_slot(1, 576, 436, 2, 1);
      check_slot(0, 288, 464, 0, 1);
      do_scroll(0, 1'b0, "mv2");
      check_slot(1, 575, 436, 2, 1);
      bus.rnd = '0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/platform_spawner.md
Name: platform_spawner

Overview:
- Consumes the 15-bit pseudo-random word from the game's LFSR source and maintains a fixed pool of platform slots (x, y, type, alive).
- On each camera scroll request it shifts every platform down and retires any platform that leaves the bottom of the screen.
- Each retired slot is immediately respawned above the current topmost platform, at a random x position, gap and type.
- Sits between the random source and the renderer/collision logic; both of those read slots through an indexed read port.

Parameters:
- SLOTS, 8, number of platform slots; power of two, ≥2.
- SCREEN_W, 640, visible width in px.
- SCREEN_H, 480, visible height in px.
- PLAT_W, 64, platform width in px; XRANGE = SCREEN_W-PLAT_W, constraint 512 ≤ XRANGE < 1024.
- MIN_GAP, 24, minimum vertical spacing between spawned platforms, px.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rnd  in  15  random word, new value every cycle
- scroll_valid  in  1  scroll request
- scroll_dy  in  5  scroll distance in px, 0..31
- scroll_ready  out  1  block can accept a scroll (IDLE state)
- rd_idx  in  $clog2(SLOTS)  slot to read
- rd_x  out  10  x of slot rd_idx, combinational from registered state
- rd_y  out  11  signed y of slot rd_idx (negative = above screen)
- rd_type  out  2  0 normal, 1 breakable, 2 moving
- rd_alive  out  1  slot holds a valid platform
- busy  out  1  INIT or SCROLL in progress

Behaviour:
- Reset state:
  - All slots: alive=0, x=0, y=0, type=0.
  - top_y=0; state=INIT; scroll_ready=0; busy=1.
- Random field extraction (spawn cycle only):
  - x = rnd[9:0] if rnd[9:0] < XRANGE, else rnd[9:0]-XRANGE.
  - gap = MIN_GAP + rnd[14:10] (range 24..55).
  - type = 1 if rnd[12:11]==2'b11, else 0.
- States:
  - INIT: one slot written per cycle, slot 0 to SLOTS-1, taking SLOTS cycles.
    - Slot 0: fixed x=XRANGE/2 (288), y=SCREEN_H-16 (464), type 0, so the player always has a landing platform.
    - Slot i>0: y = top_y - gap, with random x and type.
    - Every written slot gets alive=1 and sets top_y = its y.
    - Then go to IDLE.
  - IDLE: scroll_ready=1, busy=0. On scroll_valid, latch scroll_dy and go to SCROLL.
  - SCROLL: SLOTS+1 cycles.
    - Cycle 0: top_y += dy.
    - Cycles 1..SLOTS: process slot k = cycle-1; y_new = y+dy.
    - If y_new ≥ SCREEN_H (signed compare), respawn: y = top_y - gap, random x and type, top_y updated. This happens in the same cycle, so later respawns in the same pass chain off it.
    - Otherwise y = y_new.
    - Then go to IDLE.
- Latency: scroll_ready is high again exactly SLOTS+2 cycles after the accepting edge.
- Arithmetic: y and top_y are 11-bit signed. Spawns occur only on retirement, so y stays ≥ -(SLOTS·55) with no wrap.
- Boundary cases:
  - scroll_valid while not ready is ignored, not queued.
  - dy=0 is a full pass with no retirement.
  - Several retirements in one pass are processed in ascending slot order, each using that cycle's rnd.
  - rst at any time, including mid-SCROLL, aborts the operation and re-enters INIT with reset values.
  - Read port is valid in every state; mid-pass it shows a mix of updated and not-yet-updated slots.

Optional Feature:
- Macro PLATFORM_MOVING_EN.
- Defined:
  - A spawn gets type 2 when rnd[12:11]==2'b10.
  - Each slot carries a direction bit, cleared on spawn (0 = right).
  - During a slot's SCROLL cycle, type-2 slots move x ±1.
  - Direction flips when x reaches 0 or XRANGE; x is never outside 0..XRANGE.
- Undefined: type 2 is never produced, no direction storage, x is unchanged during scroll.

Test Plan:
- rst 1 cycle, rnd=0 → after 8 INIT cycles: slot0 (288,464); slots1..7 x=0, y=440,416,…,296, type 0; all alive; scroll_ready=1.
- After init, rnd=0, scroll dy=20 → top_y=316; slot0 y_new 484 respawns at y=292, x=0; slots1..7 y=460..316; ready high 10 cycles after accept.
- rnd=15'h7FFF during a respawn → x=447, gap=55, type=1.
- scroll_valid held high throughout a pass → exactly one scroll per IDLE cycle; request ignored while busy=1.
- rst asserted at SCROLL cycle 4 → next cycle busy=1, all rd_alive=0 for unwritten slots, INIT restarts from slot 0.
- With PLATFORM_MOVING_EN, type-2 slot at x=575 (XRANGE-1), 2 scrolls → x=576, then 575.
